// File: rtl/nrs_pkg.sv
// nrs_pkg: shared state encoding, LFSR constants and step helper for the NRS fill sequencer.
package nrs_pkg;
  typedef enum logic [1:0] {IDLE, WARMUP, FILL, DONE} state_e;
  localparam logic [30:0] X1_INIT = 31'h1;
  localparam logic [30:0] X1_TAPS = 31'h9;
  localparam logic [30:0] X2_TAPS = 31'hF;
  localparam int NC_DEFAULT = 1600;
  // Oldest element sits in bit 0; the feedback bit enters at bit 30.
  function automatic logic [30:0] lfsr_step(input logic [30:0] x, input logic [30:0] taps);
    return {^(x & taps), x[30:1]};
  endfunction
endpackage

// File: rtl/nrs_gold_lfsr.sv
// nrs_gold_lfsr: x1/x2 Gold-sequence LFSR pair; c_bit is the XOR of their oldest bits.
module nrs_gold_lfsr
  import nrs_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        shift,
  input  logic [30:0] c_init,
  output logic        c_bit
);
  logic [30:0] x1_q, x2_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x1_q <= '0;
      x2_q <= '0;
    end else if (load) begin
      x1_q <= X1_INIT;
      x2_q <= c_init;
    end else if (shift) begin
      x1_q <= lfsr_step(x1_q, X1_TAPS);
      x2_q <= lfsr_step(x2_q, X2_TAPS);
    end
  end
  assign c_bit = x1_q[0] ^ x2_q[0];
endmodule

// File: rtl/nrs_fill_ctrl.sv
// nrs_fill_ctrl: seeds the Gold LFSRs, discards NC warm-up bits, writes WIDTH_REG c(n) bits
// into the NRS register and holds buf_valid until both readers release it.
module nrs_fill_ctrl
  import nrs_pkg::*;
#(
  parameter int WIDTH_REG = 16,
  parameter int LINES     = $clog2(WIDTH_REG),
  parameter int NC        = NC_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [30:0]      c_init,
  input  logic             rel_est,
  input  logic             rel_fine,
  output logic             wr_en,
  output logic [LINES-1:0] wr_addr,
  output logic             c_n,
  output logic             busy,
  output logic             done,
  output logic             buf_valid
);
  localparam int CW = $clog2((NC > WIDTH_REG ? NC : WIDTH_REG) + 1);
  localparam logic [CW-1:0] NC_LAST = CW'(NC > 0 ? NC - 1 : 0);
  localparam logic [CW-1:0] W_LAST  = CW'(WIDTH_REG - 1);
  localparam state_e START_STATE = (NC == 0) ? FILL : WARMUP;
  state_e state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic bv_q, bv_d, est_q, est_d, fine_q, fine_d;
  logic load;
  assign load = (state_q == IDLE) && start;
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    bv_d    = bv_q;
    est_d   = est_q;
    fine_d  = fine_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = START_STATE;
          count_d = '0;
          bv_d    = 1'b0;
          est_d   = 1'b0;
          fine_d  = 1'b0;
        end else if (bv_q && est_q && fine_q) begin
          bv_d   = 1'b0;
          est_d  = 1'b0;
          fine_d = 1'b0;
        end else if (bv_q) begin
          est_d  = est_q | rel_est;
          fine_d = fine_q | rel_fine;
        end
      end
      WARMUP: begin
        state_d = (count_q == NC_LAST) ? FILL : WARMUP;
        count_d = (count_q == NC_LAST) ? '0 : count_q + 1'b1;
      end
      FILL: begin
        state_d = (count_q == W_LAST) ? DONE : FILL;
        count_d = (count_q == W_LAST) ? count_q : count_q + 1'b1;
      end
      DONE: begin
        state_d = IDLE;
        bv_d    = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      count_q <= '0;
      bv_q    <= 1'b0;
      est_q   <= 1'b0;
      fine_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      bv_q    <= bv_d;
      est_q   <= est_d;
      fine_q  <= fine_d;
    end
  end
  nrs_gold_lfsr u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .shift (state_q == WARMUP || state_q == FILL),
    .c_init(c_init),
    .c_bit (c_n)
  );
  assign wr_en     = state_q == FILL;
  assign wr_addr   = count_q[LINES-1:0];
  assign busy      = state_q != IDLE;
  assign done      = state_q == DONE;
  assign buf_valid = bv_q;
endmodule

// File: tb/tb_nrs_fill_ctrl.sv
// tb_nrs_fill_ctrl: directed checks of nrs_fill_ctrl with NC=0 (u0) and NC=1600 (u1).
module tb_nrs_fill_ctrl;
  logic clk = 1'b0;
  logic rst;
  logic [30:0] c_init;
  logic start0, re0, rf0, start1, re1, rf1;
  logic wr_en0, c_n0, busy0, done0, bv0;
  logic wr_en1, c_n1, busy1, done1, bv1;
  logic [3:0] wr_addr0, wr_addr1;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  nrs_fill_ctrl #(.WIDTH_REG(16), .NC(0)) u0 (
    .clk(clk), .rst(rst), .start(start0), .c_init(c_init), .rel_est(re0), .rel_fine(rf0),
    .wr_en(wr_en0), .wr_addr(wr_addr0), .c_n(c_n0), .busy(busy0), .done(done0), .buf_valid(bv0)
  );
  nrs_fill_ctrl #(.WIDTH_REG(16), .NC(1600)) u1 (
    .clk(clk), .rst(rst), .start(start1), .c_init(c_init), .rel_est(re1), .rel_fine(rf1),
    .wr_en(wr_en1), .wr_addr(wr_addr1), .c_n(c_n1), .busy(busy1), .done(done1), .buf_valid(bv1)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Gold sequence from its recurrence definition, not a shift register.
  function automatic logic [15:0] gold_word(input logic [30:0] ci, input int nc);
    logic a [0:1700];
    logic b [0:1700];
    logic [15:0] w;
    for (int i = 0; i < 31; i++) begin
      a[i] = (i == 0);
      b[i] = ci[i];
    end
    for (int m = 31; m < nc + 16; m++) begin
      a[m] = a[m-28] ^ a[m-31];
      b[m] = b[m-28] ^ b[m-29] ^ b[m-30] ^ b[m-31];
    end
    for (int i = 0; i < 16; i++) w[i] = a[nc+i] ^ b[nc+i];
    return w;
  endfunction

  task automatic run_fill0(input logic [30:0] ci, input logic [15:0] exp_w, input int mid, input logic rel);
    logic [15:0] w;
    w = '0;
    c_init = ci; start0 = 1; re0 = rel; rf0 = rel;
    tick;
    start0 = 0; re0 = 0; rf0 = 0;
    checks++;
    if (bv0 !== 1'b0 || busy0 !== 1'b1) begin
      errors++; $display("FAIL fill_start bv=%b busy=%b expected bv=0 busy=1", bv0, busy0);
    end
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (wr_en0 !== 1'b1 || wr_addr0 !== 4'(k)) begin
        errors++; $display("FAIL fill_write k=%0d wr_en=%b addr=%0d expected wr_en=1 addr=%0d", k, wr_en0, wr_addr0, k);
      end
      w[wr_addr0] = c_n0;
      if (k == mid) begin start0 = 1; c_init = ~ci; end
      tick;
      start0 = 0;
    end
    checks++;
    if (done0 !== 1'b1 || wr_en0 !== 1'b0 || busy0 !== 1'b1) begin
      errors++; $display("FAIL fill_done done=%b wr_en=%b busy=%b expected 1/0/1", done0, wr_en0, busy0);
    end
    tick;
    checks++;
    if (bv0 !== 1'b1 || done0 !== 1'b0 || busy0 !== 1'b0) begin
      errors++; $display("FAIL fill_valid bv=%b done=%b busy=%b expected 1/0/0", bv0, done0, busy0);
    end
    checks++;
    if (w !== exp_w) begin
      errors++; $display("FAIL fill_reg ci=%h got=%h expected=%h", ci, w, exp_w);
    end
    checks++;
    if (w !== gold_word(ci, 0)) begin
      errors++; $display("FAIL fill_model ci=%h got=%h expected=%h", ci, w, gold_word(ci, 0));
    end
  endtask

  task automatic test_reset;
    rst = 0; c_init = '0;
    start0 = 0; re0 = 0; rf0 = 0; start1 = 0; re1 = 0; rf1 = 0;
    tick; tick;
    checks++;
    if ({wr_en0, wr_addr0, c_n0, busy0, done0, bv0, wr_en1, wr_addr1, c_n1, busy1, done1, bv1} !== '0) begin
      errors++; $display("FAIL reset_outputs got u0=%b%h%b%b%b%b u1=%b%h%b%b%b%b expected all 0",
        wr_en0, wr_addr0, c_n0, busy0, done0, bv0, wr_en1, wr_addr1, c_n1, busy1, done1, bv1);
    end
    rst = 1;
    tick;
    checks++;
    if (busy0 !== 1'b0 || wr_en0 !== 1'b0) begin
      errors++; $display("FAIL idle_no_start busy=%b wr_en=%b expected 0/0", busy0, wr_en0);
    end
  endtask

  task automatic test_patterns;
    run_fill0(31'h0, 16'h0001, -1, 1'b0);
    run_fill0(31'h2, 16'h0003, -1, 1'b0);
    run_fill0(31'h1, 16'h0000, -1, 1'b0);
  endtask

  task automatic test_release;
    re0 = 1; tick; re0 = 0;
    checks++;
    if (bv0 !== 1'b1) begin errors++; $display("FAIL rel_est_only_a bv=%b expected 1", bv0); end
    tick; tick;
    checks++;
    if (bv0 !== 1'b1) begin errors++; $display("FAIL rel_est_only_b bv=%b expected 1", bv0); end
    rf0 = 1; tick; rf0 = 0;
    tick;
    checks++;
    if (bv0 !== 1'b0) begin errors++; $display("FAIL rel_both_seq bv=%b expected 0", bv0); end
    re0 = 1; tick; re0 = 0;
    run_fill0(31'h2, 16'h0003, -1, 1'b0);
    rf0 = 1; tick; rf0 = 0;
    tick; tick;
    checks++;
    if (bv0 !== 1'b1) begin errors++; $display("FAIL rel_stale_ignored bv=%b expected 1", bv0); end
    re0 = 1; rf0 = 1; tick; re0 = 0; rf0 = 0;
    tick;
    checks++;
    if (bv0 !== 1'b0) begin errors++; $display("FAIL rel_same_cycle bv=%b expected 0", bv0); end
  endtask

  task automatic test_start_while_busy;
    run_fill0(31'h0, 16'h0001, 5, 1'b0);
    run_fill0(31'h2, 16'h0003, -1, 1'b1);
    re0 = 1; tick; re0 = 0;
    tick; tick;
    checks++;
    if (bv0 !== 1'b1) begin errors++; $display("FAIL start_beats_release bv=%b expected 1", bv0); end
  endtask

  task automatic test_warmup;
    int early;
    logic [15:0] w;
    logic [15:0] exp_w;
    early = 0; w = '0;
    exp_w = gold_word(31'h1234567, 1600);
    c_init = 31'h1234567; start1 = 1; tick; start1 = 0;
    checks++;
    if (busy1 !== 1'b1 || wr_en1 !== 1'b0) begin
      errors++; $display("FAIL warmup_busy busy=%b wr_en=%b expected 1/0", busy1, wr_en1);
    end
    for (int k = 1; k <= 1600; k++) begin
      if (wr_en1 !== 1'b0 || done1 !== 1'b0) early++;
      tick;
    end
    checks++;
    if (early != 0) begin errors++; $display("FAIL warmup_quiet got %0d active cycles expected 0", early); end
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (wr_en1 !== 1'b1 || wr_addr1 !== 4'(k)) begin
        errors++; $display("FAIL warm_write cycle=%0d wr_en=%b addr=%0d expected 1/%0d", 1601 + k, wr_en1, wr_addr1, k);
      end
      w[wr_addr1] = c_n1;
      tick;
    end
    checks++;
    if (done1 !== 1'b1 || wr_en1 !== 1'b0) begin
      errors++; $display("FAIL warm_done done=%b wr_en=%b expected 1/0", done1, wr_en1);
    end
    tick;
    checks++;
    if (bv1 !== 1'b1 || done1 !== 1'b0) begin
      errors++; $display("FAIL warm_valid bv=%b done=%b expected 1/0", bv1, done1);
    end
    checks++;
    if (w !== exp_w) begin errors++; $display("FAIL warm_reg got=%h expected=%h", w, exp_w); end
  endtask

  task automatic test_async_reset;
    int bad;
    c_init = 31'h55; start1 = 1; tick; start1 = 0;
    repeat (10) tick;
    start0 = 1; tick; start0 = 0;
    tick; tick; tick;
    checks++;
    if (busy1 !== 1'b1 || wr_en0 !== 1'b1) begin
      errors++; $display("FAIL pre_reset busy1=%b wr_en0=%b expected 1/1", busy1, wr_en0);
    end
    #2 rst = 0;
    #1;
    checks++;
    if ({wr_en0, wr_addr0, c_n0, busy0, done0, bv0, wr_en1, wr_addr1, c_n1, busy1, done1, bv1} !== '0) begin
      errors++; $display("FAIL async_reset got u0=%b%h%b%b%b%b u1=%b%h%b%b%b%b expected all 0",
        wr_en0, wr_addr0, c_n0, busy0, done0, bv0, wr_en1, wr_addr1, c_n1, busy1, done1, bv1);
    end
    tick;
    rst = 1;
    bad = 0;
    for (int k = 0; k < 40; k++) begin
      if (wr_en0 | wr_en1 | busy0 | busy1 | bv0 | bv1 | done0 | done1) bad++;
      tick;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL post_reset_quiet got %0d active cycles expected 0", bad); end
    run_fill0(31'h0, 16'h0001, -1, 1'b0);
  endtask

  initial begin
    test_reset;
    test_patterns;
    test_release;
    test_start_while_busy;
    test_warmup;
    test_async_reset;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
